// File: rtl/video_dnn_frame_vote_if.sv
// Stream bundle around the frame-vote block: the per-pixel class stream in (s_*)
// and the single per-frame result beat out (m_*).
interface video_dnn_frame_vote_if #(
    parameter int TNUMBER_WIDTH = 4,
    parameter int TCOUNT_WIDTH  = 4,
    parameter int TUSER_WIDTH   = 1,
    parameter int VOTE_WIDTH    = 20
);
    // Both streams use strict AXI4-Stream valid/ready rules: a beat transfers on a
    // rising clock edge where valid and ready are both high; once valid is raised
    // the payload holds steady and valid stays high until that transfer happens.
    logic [TUSER_WIDTH-1:0]   s_axi4s_tuser;
    logic                     s_axi4s_tlast;
    logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber;
    logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount;
    logic                     s_axi4s_tvalid;
    logic                     s_axi4s_tready;

    logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber;
    logic [VOTE_WIDTH-1:0]    m_axi4s_tvote;
    logic                     m_axi4s_tdetected;
    logic                     m_axi4s_tvalid;
    logic                     m_axi4s_tready;

    modport slave (
        input  s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tnumber, s_axi4s_tcount, s_axi4s_tvalid,
        output s_axi4s_tready,
        output m_axi4s_tnumber, m_axi4s_tvote, m_axi4s_tdetected, m_axi4s_tvalid,
        input  m_axi4s_tready
    );

    modport master (
        output s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tnumber, s_axi4s_tcount, s_axi4s_tvalid,
        input  s_axi4s_tready,
        input  m_axi4s_tnumber, m_axi4s_tvote, m_axi4s_tdetected, m_axi4s_tvalid,
        output m_axi4s_tready
    );
endinterface

// File: rtl/video_dnn_frame_vote.sv
// Per-frame majority vote over a CNN per-pixel class stream: counts votes per class,
// resolves the argmax one class per cycle at frame end and emits one result beat.
module video_dnn_frame_vote #(
    parameter int NUM_CLASS     = 10,
    parameter int TNUMBER_WIDTH = 4,
    parameter int TCOUNT_WIDTH  = 4,
    parameter int TUSER_WIDTH   = 1,
    parameter int IMG_Y_WIDTH   = 12,
    parameter int VOTE_WIDTH    = 20
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [IMG_Y_WIDTH-1:0]   param_height,
    input  logic [TCOUNT_WIDTH-1:0]  param_count_th,
    video_dnn_frame_vote_if.slave    axi4s,
    output logic [7:0]               restart_count,
    output logic [1:0]               dbg_state
);
    localparam int IDX_WIDTH = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [VOTE_WIDTH-1:0]    votes [NUM_CLASS];
    logic [IMG_Y_WIDTH-1:0]   line_q, height_q;
    logic [TCOUNT_WIDTH-1:0]  th_q;
    logic [IDX_WIDTH-1:0]     ridx, best_idx;
    logic [VOTE_WIDTH-1:0]    best_vote;
    logic                     s_ready_q, m_valid_q, m_det_q;
    logic [TNUMBER_WIDTH-1:0] m_num_q;
    logic [VOTE_WIDTH-1:0]    m_vote_q;

    logic                     accept, sof_acc, frame_beat, frame_end, last_line, pixel_vote;
    logic [IMG_Y_WIDTH-1:0]   cur_height, height_eff, cur_line;
    logic [TCOUNT_WIDTH-1:0]  cur_th;
    logic                     s_ready_d, load_result, m_done;

    // A SOF beat uses the freshly presented params and a zeroed line count, so the
    // same beat can both open a new frame and close a 1-line frame.
    always_comb begin
        accept     = axi4s.s_axi4s_tvalid & s_ready_q;
        sof_acc    = accept & axi4s.s_axi4s_tuser[0];
        frame_beat = accept & ((state == ACCUM) | axi4s.s_axi4s_tuser[0]);
        cur_height = sof_acc ? param_height : height_q;
        height_eff = (cur_height == '0) ? IMG_Y_WIDTH'(1) : cur_height;
        cur_line   = sof_acc ? '0 : line_q;
        cur_th     = sof_acc ? param_count_th : th_q;
        last_line  = (cur_line == height_eff - IMG_Y_WIDTH'(1));
        frame_end  = frame_beat & axi4s.s_axi4s_tlast & last_line;
        pixel_vote = (int'(axi4s.s_axi4s_tnumber) < NUM_CLASS) &&
                     (axi4s.s_axi4s_tcount >= cur_th);
        m_done     = m_valid_q & axi4s.m_axi4s_tready;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sof_acc) next_state = frame_end ? RESOLVE : ACCUM;
            ACCUM:   if (frame_end) next_state = RESOLVE;
            RESOLVE: if (ridx == LAST_IDX) next_state = OUTPUT;
            OUTPUT:  if (m_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_ready_d   = (next_state == IDLE) || (next_state == ACCUM);
        load_result = (state == OUTPUT) && !m_valid_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int c = 0; c < NUM_CLASS; c++) votes[c] <= '0;
            line_q        <= '0;
            height_q      <= '0;
            th_q          <= '0;
            restart_count <= '0;
        end else begin
            if (sof_acc) begin
                height_q <= param_height;
                th_q     <= param_count_th;
                if ((state == ACCUM) && (restart_count != 8'hFF))
                    restart_count <= restart_count + 8'd1;
            end
            if (frame_beat) begin
                for (int c = 0; c < NUM_CLASS; c++) begin
                    if (pixel_vote && (axi4s.s_axi4s_tnumber == TNUMBER_WIDTH'(c))) begin
                        if (sof_acc)                 votes[c] <= VOTE_WIDTH'(1);
                        else if (votes[c] != '1)     votes[c] <= votes[c] + VOTE_WIDTH'(1);
                    end else if (sof_acc) begin
                        votes[c] <= '0;
                    end
                end
                if (axi4s.s_axi4s_tlast && !last_line) line_q <= cur_line + IMG_Y_WIDTH'(1);
                else                                   line_q <= cur_line;
            end
        end
    end

    // Strict greater-than walk from index 0 keeps ties on the lowest class.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ridx      <= '0;
            best_idx  <= '0;
            best_vote <= '0;
        end else if (state == RESOLVE) begin
            ridx <= ridx + IDX_WIDTH'(1);
            if (votes[ridx] > best_vote) begin
                best_vote <= votes[ridx];
                best_idx  <= ridx;
            end
        end else begin
            ridx      <= '0;
            best_idx  <= '0;
            best_vote <= '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_det_q   <= 1'b0;
            m_num_q   <= '0;
            m_vote_q  <= '0;
        end else begin
            s_ready_q <= s_ready_d;
            if (load_result) begin
                m_valid_q <= 1'b1;
                m_det_q   <= (best_vote != '0);
                m_num_q   <= (best_vote != '0) ? TNUMBER_WIDTH'(best_idx) : '0;
                m_vote_q  <= best_vote;
            end else if (m_done) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign axi4s.s_axi4s_tready    = s_ready_q;
    assign axi4s.m_axi4s_tvalid    = m_valid_q;
    assign axi4s.m_axi4s_tdetected = m_det_q;
    assign axi4s.m_axi4s_tnumber   = m_num_q;
    assign axi4s.m_axi4s_tvote     = m_vote_q;
    assign dbg_state               = state;
endmodule

// File: tb/tb_video_dnn_frame_vote.sv
// Directed bench for video_dnn_frame_vote, built with 4-bit vote counters so the
// saturation case is reachable; every other expected vote count stays below 15.
module tb_video_dnn_frame_vote;
    localparam int VW = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [11:0] param_height = '0;
    logic [3:0]  param_count_th = '0;
    logic [7:0]  restart_count;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc_cyc = 0;

    video_dnn_frame_vote_if #(
        .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(4), .TUSER_WIDTH(1), .VOTE_WIDTH(VW)
    ) vif ();

    video_dnn_frame_vote #(
        .NUM_CLASS(10), .TNUMBER_WIDTH(4), .TCOUNT_WIDTH(4), .TUSER_WIDTH(1),
        .IMG_Y_WIDTH(12), .VOTE_WIDTH(VW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .param_height  (param_height),
        .param_count_th(param_count_th),
        .axi4s         (vif),
        .restart_count (restart_count),
        .dbg_state     (dbg_state)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_beat(input bit sof, input bit last, input int num, input int cnt);
        int guard = 0;
        vif.s_axi4s_tuser   = sof;
        vif.s_axi4s_tlast   = last;
        vif.s_axi4s_tnumber = 4'(num);
        vif.s_axi4s_tcount  = 4'(cnt);
        vif.s_axi4s_tvalid  = 1'b1;
        @(negedge aclk);
        while (vif.s_axi4s_tready !== 1'b1 && guard < 200) begin
            @(negedge aclk);
            guard++;
        end
        if (guard >= 200) check_eq("s_tready_timeout", 32'd0, 32'd1);
        @(posedge aclk);
        #1;
        last_acc_cyc = cyc;
        vif.s_axi4s_tvalid = 1'b0;
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (vif.m_axi4s_tvalid !== 1'b1 && guard < 100) begin
            @(negedge aclk);
            guard++;
        end
        check_eq("m_tvalid_seen", 32'(vif.m_axi4s_tvalid), 32'd1);
    endtask

    task automatic get_result(input string tag, input int exp_num, input int exp_vote,
                              input int exp_det, input bit chk_lat);
        wait_valid();
        if (chk_lat) check_eq({tag, "_latency"}, 32'(cyc - last_acc_cyc), 32'd11);
        check_eq({tag, "_tnumber"},   32'(vif.m_axi4s_tnumber),   32'(exp_num));
        check_eq({tag, "_tvote"},     32'(vif.m_axi4s_tvote),     32'(exp_vote));
        check_eq({tag, "_tdetected"}, 32'(vif.m_axi4s_tdetected), 32'(exp_det));
        vif.m_axi4s_tready = 1'b1;
        @(posedge aclk);
        #1;
        vif.m_axi4s_tready = 1'b0;
        check_eq({tag, "_tvalid_drop"}, 32'(vif.m_axi4s_tvalid), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_s_tready"},  32'(vif.s_axi4s_tready),    32'd1);
        check_eq({tag, "_m_tvalid"},  32'(vif.m_axi4s_tvalid),    32'd0);
        check_eq({tag, "_tnumber"},   32'(vif.m_axi4s_tnumber),   32'd0);
        check_eq({tag, "_tvote"},     32'(vif.m_axi4s_tvote),     32'd0);
        check_eq({tag, "_tdetected"}, 32'(vif.m_axi4s_tdetected), 32'd0);
        check_eq({tag, "_restart"},   32'(restart_count),         32'd0);
        check_eq({tag, "_state"},     32'(dbg_state),             32'd0);
    endtask

    initial begin
        int cls_a [8];
        int high_cnt;
        cls_a = '{3, 3, 3, 7, 7, 1, 3, 9};
        vif.s_axi4s_tuser   = '0;
        vif.s_axi4s_tlast   = 1'b0;
        vif.s_axi4s_tnumber = '0;
        vif.s_axi4s_tcount  = '0;
        vif.s_axi4s_tvalid  = 1'b0;
        vif.m_axi4s_tready  = 1'b0;

        repeat (3) @(negedge aclk);
        check_reset_values("in_reset");
        aresetn = 1'b1;
        @(negedge aclk);
        check_reset_values("post_reset");

        // Stray non-SOF beat in IDLE is dropped without starting a frame.
        send_beat(1'b0, 1'b1, 3, 15);
        check_eq("idle_discard_state", 32'(dbg_state), 32'd0);

        // 4x2 frame, class 3 wins with 4 votes.
        param_height = 12'd2;
        param_count_th = 4'd0;
        for (int i = 0; i < 8; i++)
            send_beat(i == 0, (i == 3) || (i == 7), cls_a[i], $urandom_range(0, 15));
        check_eq("basic_resolve_state", 32'(dbg_state), 32'd2);
        check_eq("basic_resolve_s_tready", 32'(vif.s_axi4s_tready), 32'd0);
        get_result("basic", 3, 4, 1, 1'b1);

        // Tie between classes 5 and 2 goes to the lower index.
        param_height = 12'd1;
        send_beat(1'b1, 1'b0, 5, 9);
        send_beat(1'b0, 1'b1, 2, 9);
        get_result("tie", 2, 1, 1, 1'b1);

        // Threshold 8 blocks tcount 7; out-of-range classes never vote. Height 0 acts as 1.
        param_height = 12'd0;
        param_count_th = 4'd8;
        send_beat(1'b1, 1'b0, 2, 7);
        send_beat(1'b0, 1'b0, 5, 7);
        send_beat(1'b0, 1'b0, 12, 15);
        send_beat(1'b0, 1'b1, 15, 15);
        get_result("thresh", 0, 0, 0, 1'b1);

        // Early SOF aborts the class-4 partial frame.
        param_height = 12'd2;
        param_count_th = 4'd0;
        send_beat(1'b1, 1'b0, 4, 5);
        send_beat(1'b0, 1'b0, 4, 5);
        send_beat(1'b0, 1'b0, 4, 5);
        for (int i = 0; i < 6; i++) send_beat(i == 0, (i == 2) || (i == 5), 6, 3);
        check_eq("early_sof_restart", 32'(restart_count), 32'd1);
        get_result("early_sof", 6, 6, 1, 1'b1);

        // Backpressure: result held 20 cycles, input stalled throughout.
        param_height = 12'd1;
        send_beat(1'b1, 1'b0, 8, 1);
        send_beat(1'b0, 1'b0, 8, 1);
        send_beat(1'b0, 1'b1, 0, 1);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            check_eq("bp_tvalid",   32'(vif.m_axi4s_tvalid),  32'd1);
            check_eq("bp_tnumber",  32'(vif.m_axi4s_tnumber), 32'd8);
            check_eq("bp_tvote",    32'(vif.m_axi4s_tvote),   32'd2);
            check_eq("bp_s_tready", 32'(vif.s_axi4s_tready),  32'd0);
        end
        // Offer a 1-line SOF+tlast frame together with the result handshake.
        vif.m_axi4s_tready  = 1'b1;
        vif.s_axi4s_tuser   = 1'b1;
        vif.s_axi4s_tlast   = 1'b1;
        vif.s_axi4s_tnumber = 4'd1;
        vif.s_axi4s_tcount  = 4'd4;
        vif.s_axi4s_tvalid  = 1'b1;
        @(posedge aclk);
        #1;
        vif.m_axi4s_tready = 1'b0;
        check_eq("hs_tvalid_drop", 32'(vif.m_axi4s_tvalid), 32'd0);
        check_eq("hs_s_tready",    32'(vif.s_axi4s_tready), 32'd1);
        check_eq("hs_sof_pending", 32'(dbg_state),          32'd0);
        @(posedge aclk);
        #1;
        last_acc_cyc = cyc;
        vif.s_axi4s_tvalid = 1'b0;
        check_eq("sof_last_state", 32'(dbg_state), 32'd2);
        get_result("sof_last", 1, 1, 1, 1'b1);

        // 20 votes for class 1 saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) send_beat(i == 0, i == 19, 1, 2);
        get_result("sat", 1, 15, 1, 1'b1);
        check_eq("sat_restart_kept", 32'(restart_count), 32'd1);

        // Reset during RESOLVE drops the frame.
        send_beat(1'b1, 1'b1, 4, 2);
        repeat (3) @(negedge aclk);
        check_eq("pre_reset_state", 32'(dbg_state), 32'd2);
        aresetn = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge aclk);
        aresetn = 1'b1;
        high_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (vif.m_axi4s_tvalid === 1'b1) high_cnt++;
        end
        check_eq("no_beat_after_reset", 32'(high_cnt), 32'd0);
        check_reset_values("after_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/video_dnn_frame_vote.md
Name: video_dnn_frame_vote

Overview:
- Consumes the per-pixel classification stream produced by the MNIST CNN pipeline: AXI4-Stream with tnumber, tcount, tuser=SOF and tlast=EOL.
- Accumulates per-class pixel votes over one frame.
- At frame end, resolves the winning class and emits a single result beat on an AXI4-Stream master.
- Sits downstream of the CNN/max-count stage and feeds the result display/register logic.

Parameters:
- NUM_CLASS, 10, number of classes; tnumber values >= NUM_CLASS are ignored.
- TNUMBER_WIDTH, 4, width of class index.
- TCOUNT_WIDTH, 4, width of per-pixel confidence count.
- TUSER_WIDTH, 1, width of tuser; bit 0 is SOF.
- IMG_Y_WIDTH, 12, width of the line counter and param_height.
- VOTE_WIDTH, 20, width of each per-class vote counter (saturating).

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- param_height  input  IMG_Y_WIDTH  lines per frame; 0 treated as 1; sampled at SOF acceptance
- param_count_th  input  TCOUNT_WIDTH  minimum tcount for a pixel to vote; sampled at SOF acceptance
- s_axi4s_tuser  input  TUSER_WIDTH  bit0 = start of frame
- s_axi4s_tlast  input  1  end of line
- s_axi4s_tnumber  input  TNUMBER_WIDTH  per-pixel class
- s_axi4s_tcount  input  TCOUNT_WIDTH  per-pixel confidence
- s_axi4s_tvalid  input  1  slave valid
- s_axi4s_tready  output  1  slave ready
- m_axi4s_tnumber  output  TNUMBER_WIDTH  winning class
- m_axi4s_tvote  output  VOTE_WIDTH  winning vote count
- m_axi4s_tdetected  output  1  1 if any class got at least one vote
- m_axi4s_tvalid  output  1  result valid
- m_axi4s_tready  input  1  result ready
- restart_count  output  8  saturating count of frames aborted by early SOF

Behaviour:
- Reset values:
  - state=IDLE
  - all vote counters 0, line counter 0
  - m_axi4s_tvalid=0, m_axi4s_tnumber=0, m_axi4s_tvote=0, m_axi4s_tdetected=0
  - restart_count=0
  - s_axi4s_tready=1 (registered, from state)
- Accept condition: a beat is accepted when s_tvalid & s_tready.
- A pixel votes when tnumber < NUM_CLASS and tcount >= th. A vote increments that class counter by 1, saturating at all-ones.
- IDLE:
  - s_tready=1.
  - Beats without SOF are discarded.
  - An accepted SOF beat clears all counters, latches params, counts itself, sets line=0, and goes to ACCUM.
- ACCUM:
  - s_tready=1. Each accepted beat votes.
  - Accepted tlast: if line == height-1 (height 0 -> 1), go to RESOLVE; otherwise line++.
  - Accepted SOF mid-frame: the frame is aborted. Counters clear, the new pixel counts, line=0, restart_count++ (saturating), state stays ACCUM.
  - SOF with tlast on a 1-line frame: SOF handling applies first, then the frame completes.
- RESOLVE:
  - s_tready=0.
  - Sequential argmax, one class per cycle, index 0..NUM_CLASS-1, strict-greater compare, so ties go to the lowest index.
  - Exactly NUM_CLASS cycles, then go to OUTPUT.
- OUTPUT:
  - m_tvalid=1; outputs are stable while tvalid & !tready.
  - tdetected = (best vote != 0). When tdetected=0: tnumber=0, tvote=0.
  - On m_tready, tvalid drops on the next edge and state goes to IDLE; s_tready rises the same edge.
- Latency: the final tlast is accepted at edge N; m_tvalid is high from edge N+NUM_CLASS+1.
- Input backpressure: input is backpressured during RESOLVE/OUTPUT. No beats are lost. Upstream stalls.
- Asynchronous reset mid-frame or mid-output abandons everything immediately. No result beat is emitted.

Test Plan:
- 4x2 frame, height=2, th=0, pixel classes {3,3,3,7,7,1,3,9} -> one result beat: tnumber=3, tvote=4, tdetected=1, tvalid high exactly 11 cycles after the final tlast is accepted.
- Tie: 2x1 frame, classes {5,2}, th=0 -> tnumber=2, tvote=1 (lowest index wins).
- Threshold: th=8, all tcount=7 -> tdetected=0, tnumber=0, tvote=0; tnumber=12 pixels with tcount=15 are also ignored.
- Early SOF: SOF, 3 beats of class 4, then SOF and a full 2-line frame of class 6 -> restart_count=1, single result tnumber=6 with no class-4 votes.
- Backpressure: hold m_tready=0 for 20 cycles -> outputs stable, s_tready=0 throughout; the next frame's SOF is accepted only the cycle after the m handshake.
- Saturation and reset: VOTE_WIDTH=4, 20 pixels of class 1 -> tvote=15. Assert aresetn low during RESOLVE -> no result beat; all outputs are at reset values.
